// File: rtl/pe_pkg.sv
// Shared types, widths and saturation helpers for the convolution processing element.
package pe_pkg;

  localparam int unsigned DATA_SIZE      = 8;
  localparam int unsigned HALFWORD_WIDTH = 16;
  localparam int unsigned FRAC_BITS      = 3;

  typedef logic signed [DATA_SIZE-1:0]      data_t;
  typedef logic signed [HALFWORD_WIDTH-1:0] raw_t;

  // Clamp a wide signed value into the Q9.6 raw range.
  function automatic raw_t sat_raw(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return raw_t'(16'sh7fff);
    end else if (v < -64'sd32768) begin
      return raw_t'(16'sh8000);
    end else begin
      return raw_t'(v);
    end
  endfunction

  // Arithmetic shift floors toward -inf, then clamp to the Q4.3 range.
  function automatic data_t sat_map(input raw_t v);
    raw_t shifted;
    shifted = v >>> FRAC_BITS;
    if (shifted > 16'sd127) begin
      return data_t'(8'sh7f);
    end else if (shifted < -16'sd128) begin
      return data_t'(8'sh80);
    end else begin
      return data_t'(shifted);
    end
  endfunction

endpackage

// File: rtl/processing_element_if.sv
// Data/valid bundle between the CNN datapath and one processing element.
interface processing_element_if;
  import pe_pkg::*;

  data_t weight;
  data_t inmap;
  data_t bias;
  logic  inmap_vld;
  logic  weight_vld;
  data_t outmap;
  logic  outmap_vld;
  raw_t  outraw;

  modport master (
    output weight, inmap, bias, inmap_vld, weight_vld,
    input  outmap, outmap_vld, outraw
  );

  modport slave (
    input  weight, inmap, bias, inmap_vld, weight_vld,
    output outmap, outmap_vld, outraw
  );

endinterface

// File: rtl/pe_sat.sv
// Combinational saturate/shift stage: final sum -> Q9.6 raw and Q4.3 map.
// Optional ReLU on the map output when PE_RELU_EN is defined.
module pe_sat
  import pe_pkg::*;
#(
  parameter int unsigned SUM_WIDTH = 23
) (
  input  logic signed [SUM_WIDTH-1:0] sum,
  output raw_t                        raw,
  output data_t                       map
);

  data_t map_sat;

  always_comb begin
    raw     = sat_raw(64'(sum));
    map_sat = sat_map(raw);
`ifdef PE_RELU_EN
    map     = map_sat[DATA_SIZE-1] ? '0 : map_sat;
`else
    map     = map_sat;
`endif
  end

endmodule

// File: rtl/processing_element.sv
// Multiply-accumulates PERIOD weight/feature beats plus bias; emits saturated raw and map
// values with a one-cycle valid pulse. Build option: PE_RELU_EN clamps outmap at zero.
module processing_element
  import pe_pkg::*;
#(
  parameter int unsigned PERIOD = 25
) (
  input logic                  clk,
  input logic                  rst,
  processing_element_if.slave  bus
);

  localparam int unsigned AccW = HALFWORD_WIDTH + $clog2(PERIOD);
  // Headroom for the last product and shifted bias on top of the accumulator.
  localparam int unsigned SumW = AccW + 2;
  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  data_t                  outmap_q, outmap_d;
  raw_t                   outraw_q, outraw_d;
  logic                   vld_q, vld_d;

  logic                   beat;
  logic                   last;
  raw_t                   prod;
  logic signed [SumW-1:0] sum;
  raw_t                   sat_raw_val;
  data_t                  sat_map_val;

  assign beat = bus.inmap_vld & bus.weight_vld;
  assign last = (cnt_q == LastCnt);
  assign prod = bus.weight * bus.inmap;
  assign sum  = SumW'(acc_q) + SumW'(prod) + (SumW'(bus.bias) <<< FRAC_BITS);

  pe_sat #(
    .SUM_WIDTH (SumW)
  ) u_sat (
    .sum (sum),
    .raw (sat_raw_val),
    .map (sat_map_val)
  );

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    outmap_d = outmap_q;
    outraw_d = outraw_q;
    vld_d    = 1'b0;
    if (beat) begin
      if (last) begin
        acc_d    = '0;
        cnt_d    = '0;
        outmap_d = sat_map_val;
        outraw_d = sat_raw_val;
        vld_d    = 1'b1;
      end else begin
        acc_d = acc_q + AccW'(prod);
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      outmap_q <= '0;
      outraw_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      outmap_q <= outmap_d;
      outraw_q <= outraw_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.outmap     = outmap_q;
  assign bus.outraw     = outraw_q;
  assign bus.outmap_vld = vld_q;

endmodule

// File: tb/tb_processing_element.sv
// Bench for processing_element: directed test-plan windows plus randomized windows with gaps,
// checked every cycle against an integer-arithmetic window model.
module tb_processing_element;
  import pe_pkg::*;

  localparam int unsigned PERIOD = 25;
`ifdef PE_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  processing_element_if bus ();

  processing_element #(
    .PERIOD (PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: running window sum, beats seen, last published results.
  int m_acc;
  int m_cnt;
  int m_raw;
  int m_map;
  int m_vld;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int floor8(int v);
    return (v >= 0) ? v / 8 : -((-v + 7) / 8);
  endfunction

  function automatic int map_lit(int m);
    return (Relu && m < 0) ? 0 : m;
  endfunction

  task automatic check(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    integer raw_obs;
    integer map_obs;
    integer vld_obs;
    raw_obs = bus.outraw;
    map_obs = bus.outmap;
    vld_obs = {31'd0, bus.outmap_vld};
    check({tag, "_vld"}, vld_obs, m_vld);
    check({tag, "_raw"}, raw_obs, m_raw);
    check({tag, "_map"}, map_obs, m_map);
  endtask

  task automatic beat(input int w, input int x, input int b, input bit wv, input bit xv,
                      input string tag);
    int s;
    bus.weight     = data_t'(w);
    bus.inmap      = data_t'(x);
    bus.bias       = data_t'(b);
    bus.weight_vld = wv;
    bus.inmap_vld  = xv;
    @(posedge clk);
    #1;
    m_vld = 0;
    if (wv && xv) begin
      m_acc += w * x;
      m_cnt++;
      if (m_cnt == PERIOD) begin
        s     = m_acc + b * 8;
        m_raw = clampi(s, -32768, 32767);
        m_map = clampi(floor8(m_raw), -128, 127);
        if (Relu && m_map < 0) m_map = 0;
        m_vld = 1;
        m_acc = 0;
        m_cnt = 0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic window(input int w, input int x, input int b, input string tag);
    for (int i = 0; i < PERIOD; i++) beat(w, x, b, 1'b1, 1'b1, tag);
  endtask

  task automatic check_lit(input string tag, input int raw_exp, input int map_exp);
    integer raw_obs;
    integer map_obs;
    raw_obs = bus.outraw;
    map_obs = bus.outmap;
    check({tag, "_lit_raw"}, raw_obs, raw_exp);
    check({tag, "_lit_map"}, map_obs, map_lit(map_exp));
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    m_acc = 0;
    m_cnt = 0;
    m_raw = 0;
    m_map = 0;
    m_vld = 0;
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    rst = 1'b1;
  endtask

  initial begin
    int w;
    int x;
    int b;
    bit wv;
    bit xv;
    rst            = 1'b0;
    bus.weight     = '0;
    bus.inmap      = '0;
    bus.bias       = '0;
    bus.weight_vld = 1'b0;
    bus.inmap_vld  = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    m_raw = 0;
    m_map = 0;
    m_vld = 0;
    #12;
    check_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Test-plan scenarios with literal expectations.
    window(5, 3, 2, "s1");
    check_lit("s1", 391, 48);
    beat(0, 0, 0, 1'b0, 1'b0, "s1_idle");
    check_lit("s1_hold", 391, 48);
    window(-125, 2, 2, "s2");
    check_lit("s2", -6234, -128);
    window(0, 0, 2, "s3");
    check_lit("s3", 16, 2);
    window(14, -1, 1, "s4");
    check_lit("s4", -342, -43);
    window(127, 127, 0, "sat_pos");
    check_lit("sat_pos", 32767, 127);
    window(-128, 127, 0, "sat_neg");
    check_lit("sat_neg", -32768, -128);

    // Gaps and single-sided valids mid-window.
    for (int i = 0; i < 10; i++) beat(5, 3, 2, 1'b1, 1'b1, "gap");
    beat(99, 99, 0, 1'b1, 1'b0, "gap_w_only");
    beat(99, 99, 0, 1'b0, 1'b1, "gap_x_only");
    beat(99, 99, 0, 1'b0, 1'b0, "gap_none");
    for (int i = 10; i < PERIOD; i++) beat(5, 3, 2, 1'b1, 1'b1, "gap");
    check_lit("gap", 391, 48);

    // Reset mid-window discards the partial sum.
    for (int i = 0; i < 10; i++) beat(7, 7, 3, 1'b1, 1'b1, "pre_rst");
    apply_reset("mid_rst");
    window(5, 3, 2, "post_rst");
    check_lit("post_rst", 391, 48);

    // Randomized windows with random gaps.
    for (int n = 0; n < 6 * PERIOD; n++) begin
      w  = int'($urandom_range(255)) - 128;
      x  = int'($urandom_range(255)) - 128;
      b  = int'($urandom_range(255)) - 128;
      wv = ($urandom_range(7) != 0);
      xv = ($urandom_range(7) != 0);
      beat(w, x, b, wv, xv, "rand");
    end
    // Small-magnitude random windows land away from saturation.
    for (int n = 0; n < 3 * PERIOD; n++) begin
      w  = int'($urandom_range(31)) - 16;
      x  = int'($urandom_range(31)) - 16;
      b  = int'($urandom_range(63)) - 32;
      beat(w, x, b, 1'b1, 1'b1, "rand_small");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/processing_element.md
# processing_element

Convolution processing element for the CNN datapath. It multiply-accumulates PERIOD signed fixed-point weight/feature pairs, adds a bias, and emits both a 16-bit raw sum and a saturated 8-bit output map value with a one-cycle valid pulse. One instance computes one output pixel per window; the default PERIOD of 25 corresponds to a 5x5 kernel.

## Interface
- PERIOD, 25, number of accepted input beats per accumulation window (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- weight  in  8  signed two's complement, Q4.3 (LSB = 1/8)
- inmap  in  8  signed, Q4.3
- inmap_vld  in  1  inmap valid
- weight_vld  in  1  weight valid
- bias  in  8  signed, Q4.3
- outmap  out  8  signed Q4.3 result, saturated
- outmap_vld  out  1  one-cycle pulse, outmap/outraw updated
- outraw  out  16  signed Q9.6 (LSB = 1/64) value of Σw·x + b, saturated

## Operation
- Beat accepted on a clk edge when inmap_vld && weight_vld. A beat with only one valid high is ignored.
- Product: 8x8 signed → 16-bit Q.6, exact.
- Accumulator: signed, 16+ceil(log2(PERIOD)) bits (21 bits at default). Cannot overflow internally.
- Beat counter runs 0..PERIOD-1. On the beat where the counter equals PERIOD-1:
  - Final sum = acc + product + (sign-extended bias <<< 3), with bias sampled on this beat.
  - outraw = sum saturated to [-32768, 32767].
  - outmap = (saturated sum) >>> 3, floor (truncation toward -inf), saturated to [-128, 127].
  - Accumulator and counter clear, so the next beat starts a new window with no bubble.
- outmap and outraw hold their value between windows.
- Reset (rst=0, any time, including mid-window): accumulator, counter, outmap, outraw and outmap_vld all become 0. A partial window is discarded.

## Timing
- outmap, outraw and outmap_vld are registered. They update on the edge that accepts the PERIOD-th beat, so latency is 1 cycle from that beat's presentation.
- outmap_vld is high for exactly one cycle per window. Back-to-back windows produce a pulse every PERIOD cycles.
- There is no backpressure, and input gaps are allowed anywhere in a window.

## Configuration
- PE_RELU_EN defined: outmap = max(0, saturated value). outraw is unaffected.
- PE_RELU_EN undefined: outmap is the signed saturated value.

## Structure
- Package pe_pkg holds:
  - DATA_SIZE = 8
  - HALFWORD_WIDTH = 16
  - FRAC_BITS = 3
  - saturation helper function
  - typedefs for data_t (signed 8) and raw_t (signed 16)
- One sub-module, pe_sat. It is a combinational saturate/shift stage that maps the accumulator to outraw/outmap, including the optional ReLU.

## Test plan
All scenarios use PERIOD=25 with 25 consecutive valid beats.
- w=5, x=3, b=2 → outraw=391 (6.109), outmap=48 (6.0), one outmap_vld pulse 1 cycle after beat 25.
- w=-125, x=2, b=2 → outraw=-6234, outmap=-128. With PE_RELU_EN, outmap=0.
- w=0, x=0, b=2 → outraw=16, outmap=2. w=14, x=-1, b=1 → outraw=-342, outmap=-43.
- w=127, x=127 → outraw=32767, outmap=127 (saturation). w=-128, x=127 → outraw=-32768, outmap=-128.
- Valid gaps and single-sided valids inserted mid-window → results identical to the first scenario, pulse delayed by the gap length.
- rst low after 10 beats, then 25 beats of the first scenario → all outputs 0 during reset, then outraw=391 with no carry-over.
